regwrite_scheduler: RTL

Write-port scheduler and scoreboard for the 32 x 32-bit register file. It arbitrates the file's single write port between the in-order pipeline writeback (WB) and the long-latency unit (LU, multiply/divide or load miss) and drives RegWrite/Write_r/Data into the register file. It tracks registers with outstanding LU results in a scoreboard and flags decode-stage hazards so the pipeline stalls instead of reading stale data.

---
 rtl/regwrite_scheduler_if.sv | 36 +++
 rtl/regwrite_scheduler.sv | 92 +++++++++
 2 files changed

// File: rtl/regwrite_scheduler_if.sv
// Bundle of the register-file write-port scheduler signals: WB and LU write
// requests, decode hazard query and the registered register-file write port.
interface regwrite_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              Wb_valid;
  logic [4:0]        Wb_r;
  logic [DATA_W-1:0] Wb_data;
  logic              Wb_stall;
  logic              Lu_valid;
  logic [4:0]        Lu_r;
  logic [DATA_W-1:0] Lu_data;
  logic              Lu_ready;
  logic [4:0]        Dec_rs;
  logic [4:0]        Dec_rt;
  logic [4:0]        Dec_rd;
  logic              Dec_wr;
  logic              Iss_valid;
  logic              Hazard;
  logic              RegWrite;
  logic [4:0]        Write_r;
  logic [DATA_W-1:0] Data;
  logic [31:0]       Busy;

  modport slave (
    input  Wb_valid, Wb_r, Wb_data, Lu_valid, Lu_r, Lu_data,
           Dec_rs, Dec_rt, Dec_rd, Dec_wr, Iss_valid,
    output Wb_stall, Lu_ready, Hazard, RegWrite, Write_r, Data, Busy
  );

  modport master (
    output Wb_valid, Wb_r, Wb_data, Lu_valid, Lu_r, Lu_data,
           Dec_rs, Dec_rt, Dec_rd, Dec_wr, Iss_valid,
    input  Wb_stall, Lu_ready, Hazard, RegWrite, Write_r, Data, Busy
  );
endinterface

// File: rtl/regwrite_scheduler.sv
// Write-port arbiter (WB over LU) plus outstanding-LU-result scoreboard.
// Optional LU anti-starvation is enabled by defining REGWR_ANTISTARVE_EN.
module regwrite_scheduler #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  regwrite_scheduler_if.slave bus
);

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

  logic              grant_wb;
  logic              grant_lu;
  logic              force_lu;
  logic              lu_hs;
  logic              hazard;
  logic              issue;
  logic [31:0]       busy;
  logic [31:0]       busy_next;
  logic              reg_write;
  logic [4:0]        write_r;
  logic [DATA_W-1:0] data;

`ifdef REGWR_ANTISTARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_lu     = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign bus.Wb_stall = !rst && bus.Wb_valid && force_lu;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              starve_cnt <= '0;
    else if (grant_lu || !bus.Lu_valid)   starve_cnt <= '0;
    else                                  starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign force_lu     = 1'b0;
  assign bus.Wb_stall = 1'b0;
`endif

  // All combinational handshakes are forced low while reset is asserted.
  assign grant_wb     = !rst && bus.Wb_valid && !force_lu;
  assign grant_lu     = !rst && bus.Lu_valid && !grant_wb;
  assign lu_hs        = grant_lu;
  assign bus.Lu_ready = grant_lu;

  assign hazard     = !rst && (busy[bus.Dec_rs] || busy[bus.Dec_rt] ||
                               (bus.Dec_wr && busy[bus.Dec_rd]));
  assign bus.Hazard = hazard;
  assign issue      = bus.Iss_valid && bus.Dec_wr && !hazard && (bus.Dec_rd != 5'd0);

  // NOTE: busy_next gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    busy_next = busy;
    if (lu_hs) busy_next[bus.Lu_r] = 1'b0;
    if (issue) busy_next[bus.Dec_rd] = 1'b1;   // set wins over a same-index clear
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      reg_write <= 1'b0;
      write_r   <= '0;
      data      <= '0;
    end else begin
      busy      <= busy_next;
      // r0 writes complete the handshake but never reach the register file.
      reg_write <= (grant_wb && bus.Wb_r != 5'd0) || (grant_lu && bus.Lu_r != 5'd0);
      if (grant_wb) begin
        write_r <= bus.Wb_r;
        data    <= bus.Wb_data;
      end else if (grant_lu) begin
        write_r <= bus.Lu_r;
        data    <= bus.Lu_data;
      end
    end
  end

  assign bus.RegWrite = reg_write;
  assign bus.Write_r  = write_r;
  assign bus.Data     = data;
  assign bus.Busy     = busy;

endmodule
